uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin packet arbiter that shares the single UART transmit path between `N_REQ` independent byte-stream requesters. It sits in front of the UART top level. Its output drives `data_valid`/`data_in_tx` and is back-pressured by a TX-FIFO-not-full indication. Grant is held for a whole packet, delimited by `req_last`. A stalled requester is evicted after a programmable idle timeout.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `DATA_WIDTH`, default 8: byte width, matches the UART `DATA_WIDTH`.
- `TIMEOUT_CYCLES`, default 1024: consecutive requester-idle cycles in SEND before eviction, ≥2.
- `clk` (in, 1): single clock.
- `rst_n` (in, 1): asynchronous, active-low reset.
- `req_valid` (in, N_REQ): per-requester byte valid.
- `req_data` (in, N_REQ×DATA_WIDTH): packed `[N_REQ-1:0][DATA_WIDTH-1:0]`.
- `req_last` (in, N_REQ): current byte ends the packet.
- `req_ready` (out, N_REQ): byte accepted from requester i when `req_valid[i] && req_ready[i]`.
- `out_valid` (out, 1): byte for UART TX; maps to `data_valid`.
- `out_data` (out, DATA_WIDTH): maps to `data_in_tx`.
- `out_ready` (in, 1): downstream can accept, i.e. TX FIFO not full.
- `busy` (out, 1): a packet is granted.
- `grant_id` (out, $clog2(N_REQ)): current or most recent grantee.
- `timeout_err` (out, 1): one-cycle pulse on eviction.
- `timeout_src` (out, $clog2(N_REQ)): requester evicted, held until the next eviction.

## Operation
- States: IDLE, SEND.
- **IDLE.** If any `req_valid` is set, pick the first set bit searching from `last_grant+1` upward with wrap. Register it as `grant_id` and `last_grant`, then go to SEND. Otherwise stay.
- **SEND combinational path:**
  - `out_valid = req_valid[grant_id]`
  - `out_data = req_data[grant_id]`
  - `req_ready[grant_id] = out_ready`
  - every other `req_ready` bit is 0.
- **Transfer** means `out_valid && out_ready`.
  - Transfer with `req_last[grant_id]` set: go to IDLE.
  - Transfer without `req_last`: stay in SEND.
- **Idle counter** (width $clog2(TIMEOUT_CYCLES+1)):
  - Increments each SEND cycle with `req_valid[grant_id]==0`.
  - Clears whenever `req_valid[grant_id]==1`, and on entry to SEND.
  - Cycles stalled by `out_ready==0` never count.
- **Eviction.** When the counter reaches `TIMEOUT_CYCLES-1` while still idle:
  - pulse `timeout_err`
  - load `timeout_src = grant_id`
  - go to IDLE.
  - The packet is truncated. The arbiter does not flush the requester.
- `busy` = (state == SEND).
- Requests asserted during SEND wait. Fairness: after a grant, that requester has the lowest priority.
- **Boundaries:**
  - A single-byte packet (`req_last` on the first byte) is legal: one transfer, then IDLE.
  - If the winner drops `req_valid` after being granted, SEND idles and eventually times out.
  - A `last` byte coinciding with the timeout threshold: the transfer wins and there is no `timeout_err`.
  - `out_ready` low indefinitely: no timeout, grant held.
  - Requester-index wrap from `N_REQ-1` to 0 is required.
- **Reset (async, any time, mid-packet included):**
  - state IDLE
  - `last_grant = N_REQ-1`, so requester 0 has first priority
  - `grant_id=0`, `timeout_src=0`, counter 0
  - all outputs 0 (`out_valid`, `req_ready`, `busy`, `timeout_err`).

## Timing
- Arbitration latency is 1 cycle: `req_valid` sampled in IDLE at edge k gives `busy=1` and a possible first transfer in cycle k+1.
- Data path is combinational from `req_*` and `out_ready` to `out_*` and `req_ready`. There is no added latency per byte.
- Sustained throughput is 1 byte/cycle within a packet.
- There is exactly one IDLE bubble cycle between packets, even back-to-back.
- `timeout_err` is registered and asserts in the cycle after the threshold edge, coincident with state IDLE.
- Eviction occurs `TIMEOUT_CYCLES` idle cycles after the last valid or grant.

## Structure
- **Package `uart_arb_pkg`:**
  - `arb_state_t` enum {IDLE, SEND}
  - function `rr_next(req, last)` returning the next index.
- **Sub-module `rr_arbiter`:** purely combinational round-robin priority select. Inputs: `req` vector and `last_grant`. Outputs: `found` and `index`. It is reusable for the RX-side fan-out.
- The top holds the FSM, grant and last-grant registers, idle counter, and muxes.

## Test plan
- **Reset and single packet.** Reset; requester 2 sends 0x41, 0x42, 0x43 (last on 0x43) with `out_ready=1`.
  - `out_data` sequence is 41, 42, 43 on three consecutive cycles.
  - `grant_id=2`.
  - Returns to IDLE; `busy` falls the cycle after 0x43.
- **Round-robin fairness.** All four requesters valid, each sending 2-byte packets.
  - Grant order is 0, 1, 2, 3, 0.
  - Exactly one bubble cycle between packets.
  - No interleaving of bytes from different requesters.
- **Back-pressure.** Requester 1 sends 0x10, 0x11 (last) with `out_ready` low for 2000 cycles, then high.
  - No `timeout_err`.
  - Both bytes delivered in order once `out_ready` rises.
  - `req_ready[1]` tracks `out_ready`.
- **Timeout.** `TIMEOUT_CYCLES=8`; requester 3 sends 0x55, then drops `req_valid` while requester 0 waits.
  - `timeout_err` pulses once, 8 cycles after the byte.
  - `timeout_src=3`.
  - Requester 0 is granted next.
- **Wrap and single-byte packets.** `last_grant=3`; requesters 3 and 1 valid with 1-byte packets.
  - Requester 1 is granted before requester 3.
  - Each packet produces one transfer.
- **Async reset mid-packet.** Assert `rst_n=0` mid-packet during byte 2 of 4.
  - `out_valid`, `req_ready` and `busy` drop immediately.
  - After release, requester 0 has priority.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and helpers for the UART TX packet arbiter.
//   arb_state_t : arbiter FSM state (IDLE / SEND)
//   rr_next()   : round-robin search, first set request after 'last' with wrap
// ----------------------------------------------------------------------------
package uart_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_t;

    // Widest requester vector the search helper supports.
    localparam int RR_MAX_REQ = 16;
    localparam int RR_IDX_W   = $clog2(RR_MAX_REQ);

    // Returns the index of the first set bit of req[n-1:0], searching from
    // last+1 upward and wrapping to 0. Returns 'last' when no bit is set.
    // The loop has a fixed bound so it unrolls into plain priority logic.
    function automatic int rr_next(input logic [RR_MAX_REQ-1:0] req,
                                   input int                    last,
                                   input int                    n);
        int   idx;
        int   result;
        logic hit;
        result = last;
        hit    = 1'b0;
        for (int i = 1; i <= RR_MAX_REQ; i++) begin
            idx = last + i;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!hit && (i <= n) && req[idx[RR_IDX_W-1:0]]) begin
                result = idx;
                hit    = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Byte-stream bus between N_REQ requesters, the arbiter and the UART TX path.
//   req_valid/req_data/req_last/req_ready : per-requester byte handshake
//   out_valid/out_data/out_ready          : merged stream towards the TX FIFO
// Modports:
//   master : the arbiter (consumes requests, produces the merged stream)
//   slave  : the environment (requesters plus TX FIFO)
// ----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8
);
    logic [N_REQ-1:0]                 req_valid;
    logic [N_REQ-1:0][DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]                 req_last;
    logic [N_REQ-1:0]                 req_ready;
    logic                             out_valid;
    logic [DATA_WIDTH-1:0]            out_data;
    logic                             out_ready;

    modport master (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data
    );

    modport slave (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data
    );
endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin priority select; also used on the RX side.
//   req        (in)  : request vector
//   last_grant (in)  : index granted most recently (lowest priority now)
//   found      (out) : at least one request is set
//   index      (out) : winning index, searched from last_grant+1 with wrap
// ----------------------------------------------------------------------------
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_grant,
    output logic             found,
    output logic [IW-1:0]    index
);

    logic [RR_MAX_REQ-1:0] req_ext;

    always_comb begin
        req_ext            = '0;
        req_ext[N_REQ-1:0] = req;
    end

    assign found = |req;
    assign index = IW'(rr_next(req_ext, int'(last_grant), N_REQ));

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin packet arbiter sharing one UART TX path between N_REQ byte
// streams. A grant is held for a whole packet (ended by req_last); a grantee
// that stays idle for TIMEOUT_CYCLES cycles is evicted.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : requester handshakes and merged output stream (master side)
//   busy        : a packet is granted (state SEND)
//   grant_id    : current or most recent grantee
//   timeout_err : one-cycle pulse on eviction
//   timeout_src : last evicted requester, held until the next eviction
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int N_REQ          = 4,
    parameter  int DATA_WIDTH     = 8,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int IW             = $clog2(N_REQ),
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_tx_arbiter_if.master    bus,
    output logic                 busy,
    output logic [IW-1:0]        grant_id,
    output logic                 timeout_err,
    output logic [IW-1:0]        timeout_src
);

    arb_state_t            state;
    arb_state_t            state_nxt;
    logic [IW-1:0]         last_grant;
    logic [CNT_W-1:0]      idle_cnt;

    logic                  arb_found;
    logic [IW-1:0]         arb_index;

    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  xfer;
    logic                  evict;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .found      (arb_found),
        .index      (arb_index)
    );

    // Grantee's request lines.
    assign sel_valid = bus.req_valid[grant_id];
    assign sel_last  = bus.req_last[grant_id];
    assign sel_data  = bus.req_data[grant_id];

    assign xfer  = (state == SEND) && sel_valid && bus.out_ready;
    // Eviction needs the grantee idle, so a last byte arriving exactly at the
    // threshold is a transfer and can never also raise timeout_err.
    assign evict = (state == SEND) && !sel_valid &&
                   (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking (<=) so every flop
            // samples pre-edge values regardless of process ordering.
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        // NOTE: default assignment first, so no path leaves state_nxt
        // unassigned and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (arb_found) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (xfer && sel_last) begin
                    state_nxt = IDLE;
                end else if (evict) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    // Data path is combinational from the grantee and out_ready: no per-byte
    // latency, one byte per cycle inside a packet.
    always_comb begin
        busy          = (state == SEND);
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.req_ready = '0;
        if (state == SEND) begin
            bus.out_valid           = sel_valid;
            bus.out_data            = sel_data;
            bus.req_ready[grant_id] = bus.out_ready;
        end
    end

    // ---------------- grant, idle counter, timeout ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id    <= '0;
            last_grant  <= IW'(N_REQ - 1);   // requester 0 wins first
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
            timeout_src <= '0;
        end else begin
            timeout_err <= evict;

            if ((state == IDLE) && arb_found) begin
                grant_id   <= arb_index;
                last_grant <= arb_index;
            end

            // Cleared in IDLE (hence on entry to SEND) and whenever the
            // grantee presents a byte, stalled by out_ready or not.
            if ((state == IDLE) || sel_valid) begin
                idle_cnt <= '0;
            end else if (!evict) begin
                idle_cnt <= idle_cnt + CNT_W'(1);
            end

            if (evict) begin
                timeout_src <= grant_id;
            end
        end
    end

endmodule
